// File: rtl/hazard_pkg.sv
// Shared types and constants for the multi-cycle hazard unit.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/hazard_unit_mc_multicycle_ctrl.sv
// Multi-cycle execute controller: holds an E-stage op for LATENCY cycles.
// The first cycle of an op is spent in IDLE; BUSY counts cycles 1..LATENCY-1.
module multicycle_ctrl
    import hazard_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic multi_i,
    output logic mul_stall_o,
    output logic done_o
);

    localparam int              CW    = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0]   LAST  = CW'(LATENCY - 1);
    localparam logic [CW-1:0]   ONE   = CW'(1);
    localparam bit              MULTI = (LATENCY > 1);

    mc_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // State and cycle-counter registers; reset returns to IDLE from anywhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: start on a multi op, count to LATENCY-1, abort if MultiE drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MC_IDLE: begin
                cnt_d = '0;
                if (multi_i && MULTI) begin
                    state_d = MC_BUSY;
                    cnt_d   = ONE;
                end
            end
            MC_BUSY: begin
                if (!multi_i || cnt_q >= LAST) begin
                    state_d = MC_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = MC_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: stall until the final cycle, pulse done on the final cycle.
    always_comb begin
        mul_stall_o = 1'b0;
        done_o      = 1'b0;
        if (!reset && multi_i) begin
            if (MULTI) begin
                mul_stall_o = (state_q == MC_IDLE) || (cnt_q < LAST);
                done_o      = (state_q == MC_BUSY) && (cnt_q == LAST);
            end else begin
                done_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for a 5-stage RISC-V pipeline: forwarding, load-use stall,
// branch flush and a multi-cycle execute hold.
// Optional feature macro: HAZARD_PERF_EN enables saturating stall/flush counters.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE,
    input  logic              PCSrcE,
    input  logic              MultiE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MultiDoneE,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    logic lw_stall;
    logic mul_stall;

    // M beats W; x0 is never forwarded since it always reads as zero.
    function automatic fwd_sel_e fwd_sel(input logic [REG_AW-1:0] rs);
        if (RegWriteM && (RdM == rs) && (rs != '0))
            return FWD_M;
        else if (RegWriteW && (RdW == rs) && (rs != '0))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    // Forwarding selects and load-use detection.
    always_comb begin
        ForwardAE = fwd_sel(Rs1E);
        ForwardBE = fwd_sel(Rs2E);
        lw_stall  = ResultSrcE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    end

    multicycle_ctrl #(
        .LATENCY (LATENCY)
    ) u_mc (
        .clk         (clk),
        .reset       (reset),
        .multi_i     (MultiE),
        .mul_stall_o (mul_stall),
        .done_o      (MultiDoneE)
    );

    // Stall/flush combination; a multi-cycle hold overrides the load bubble.
    always_comb begin
        StallF = lw_stall | mul_stall;
        StallD = lw_stall | mul_stall;
        StallE = mul_stall;
        FlushD = PCSrcE;
        FlushE = (lw_stall & ~mul_stall) | PCSrcE;
        FlushM = mul_stall;
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    // Next counter values, saturating at all-ones.
    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, StallF);
        flush_cnt_d = sat_inc(flush_cnt_q, FlushE);
    end

    // Counter registers; reset cycles are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc (LATENCY=4 and LATENCY=1 instances).
module tb_hazard_unit_mc;

    localparam int AW    = 5;
    localparam int LAT   = 4;
    localparam int CW    = 3;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic [AW-1:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic          RegWriteM = 1'b0, RegWriteW = 1'b0, ResultSrcE = 1'b0, PCSrcE = 1'b0, MultiE = 1'b0;

    logic [1:0]    fa, fb, fa1, fb1;
    logic          sf, sd, se, fd, fe, fm, dn;
    logic          sf1, sd1, se1, fd1, fe1, fm1, dn1;
    logic [CW-1:0] scnt, fcnt, scnt1, fcnt1;

    hazard_unit_mc #(.REG_AW(AW), .LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MultiE(MultiE),
        .ForwardAE(fa), .ForwardBE(fb), .StallF(sf), .StallD(sd), .StallE(se),
        .FlushD(fd), .FlushE(fe), .FlushM(fm), .MultiDoneE(dn),
        .StallCount(scnt), .FlushCount(fcnt));

    hazard_unit_mc #(.REG_AW(AW), .LATENCY(1), .CNT_W(CW)) dut1 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MultiE(MultiE),
        .ForwardAE(fa1), .ForwardBE(fb1), .StallF(sf1), .StallD(sd1), .StallE(se1),
        .FlushD(fd1), .FlushE(fe1), .FlushM(fm1), .MultiDoneE(dn1),
        .StallCount(scnt1), .FlushCount(fcnt1));

    typedef struct {
        int fa, fb, sf, se, fd, fe, fm, dn, scnt, fcnt;
        int fa1, sf1, se1, fe1, fm1, dn1, scnt1, fcnt1;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_err = 0;

    // reference model state: cycles the current multi op has spent in E
    int age = 0;
    int sc = 0, fc = 0, sc1 = 0, fc1 = 0;

    // staged stimulus
    logic          s_reset;
    logic [AW-1:0] s_rs1d, s_rs2d, s_rs1e, s_rs2e, s_rde, s_rdm, s_rdw;
    logic          s_rwm, s_rww, s_ld, s_br, s_mul;

    function automatic int ref_fwd(logic [AW-1:0] rs);
        if (RegWriteM && RdM == rs && rs != 0) return 2;
        if (RegWriteW && RdW == rs && rs != 0) return 1;
        return 0;
    endfunction

    function automatic int sat(int v, int inc);
        return (v + inc > CMAX) ? CMAX : v + inc;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stage();
        s_reset = 1'b0;
        s_rs1d = '0; s_rs2d = '0; s_rs1e = '0; s_rs2e = '0;
        s_rde = '0; s_rdm = '0; s_rdw = '0;
        s_rwm = 1'b0; s_rww = 1'b0; s_ld = 1'b0; s_br = 1'b0; s_mul = 1'b0;
    endtask

    // One clock: advance model with the inputs the DUT just sampled, then
    // apply the staged inputs and queue the expected response.
    task automatic step();
        int lw, mul, done;
        @(posedge clk);
        if (reset) begin
            age = 0; sc = 0; fc = 0; sc1 = 0; fc1 = 0;
        end else begin
            sc  = sat(sc, cur.sf);   fc  = sat(fc, cur.fe);
            sc1 = sat(sc1, cur.sf1); fc1 = sat(fc1, cur.fe1);
            age = (MultiE && cur.dn == 0) ? age + 1 : 0;
        end
        #1;
        reset = s_reset; Rs1D = s_rs1d; Rs2D = s_rs2d; Rs1E = s_rs1e; Rs2E = s_rs2e;
        RdE = s_rde; RdM = s_rdm; RdW = s_rdw; RegWriteM = s_rwm; RegWriteW = s_rww;
        ResultSrcE = s_ld; PCSrcE = s_br; MultiE = s_mul;

        lw   = (ResultSrcE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE)) ? 1 : 0;
        mul  = (!reset && MultiE && age < LAT - 1) ? 1 : 0;
        done = (!reset && MultiE && age == LAT - 1) ? 1 : 0;
        cur.fa = ref_fwd(Rs1E);
        cur.fb = ref_fwd(Rs2E);
        cur.sf = (lw || mul) ? 1 : 0;
        cur.se = mul;
        cur.fd = PCSrcE ? 1 : 0;
        cur.fe = ((lw && !mul) || PCSrcE) ? 1 : 0;
        cur.fm = mul;
        cur.dn = done;
        cur.fa1 = cur.fa;
        cur.sf1 = lw;
        cur.se1 = 0;
        cur.fm1 = 0;
        cur.fe1 = (lw || PCSrcE) ? 1 : 0;
        cur.dn1 = (!reset && MultiE) ? 1 : 0;
`ifdef HAZARD_PERF_EN
        cur.scnt = sc; cur.fcnt = fc; cur.scnt1 = sc1; cur.fcnt1 = fc1;
`else
        cur.scnt = 0; cur.fcnt = 0; cur.scnt1 = 0; cur.fcnt1 = 0;
`endif
        sb.push_back(cur);
    endtask

    // Monitor: compare every presented response against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ForwardAE", int'(fa), e.fa);
                chk("ForwardBE", int'(fb), e.fb);
                chk("StallF", int'(sf), e.sf);
                chk("StallD", int'(sd), e.sf);
                chk("StallE", int'(se), e.se);
                chk("FlushD", int'(fd), e.fd);
                chk("FlushE", int'(fe), e.fe);
                chk("FlushM", int'(fm), e.fm);
                chk("MultiDoneE", int'(dn), e.dn);
                chk("StallCount", int'(scnt), e.scnt);
                chk("FlushCount", int'(fcnt), e.fcnt);
                chk("L1_ForwardAE", int'(fa1), e.fa1);
                chk("L1_StallF", int'(sf1), e.sf1);
                chk("L1_StallE", int'(se1), e.se1);
                chk("L1_FlushE", int'(fe1), e.fe1);
                chk("L1_FlushM", int'(fm1), e.fm1);
                chk("L1_MultiDoneE", int'(dn1), e.dn1);
                chk("L1_StallCount", int'(scnt1), e.scnt1);
                chk("L1_FlushCount", int'(fcnt1), e.fcnt1);
            end
        end
    end

    initial begin
        cur = '{default: 0};
        // reset
        clear_stage(); s_reset = 1'b1;
        repeat (2) step();
        // forwarding priority
        clear_stage(); s_rdm = 5; s_rdw = 5; s_rs1e = 5; s_rs2e = 5; s_rwm = 1; s_rww = 1; step();
        s_rwm = 0; step();
        s_rs1e = 0; s_rdm = 0; s_rwm = 1; step();
        // load-use
        clear_stage(); s_ld = 1; s_rde = 7; s_rs2d = 7; step();
        s_rde = 0; step();
        // full multi op then idle
        clear_stage(); s_mul = 1; repeat (LAT) step();
        s_mul = 0; step();
        // reset in cycle 1 of BUSY, then a full op
        s_mul = 1; step(); step();
        s_reset = 1; step(); step();
        s_reset = 0; repeat (LAT) step();
        clear_stage(); step();
        // branch with load-use
        s_br = 1; s_ld = 1; s_rde = 3; s_rs1d = 3; step();
        // nine stall cycles to saturate the counter
        clear_stage(); s_ld = 1; s_rde = 9; s_rs1d = 9; repeat (9) step();
        clear_stage(); step();
        // MultiE dropped mid-op
        s_mul = 1; step(); step(); s_mul = 0; step(); s_mul = 1; repeat (LAT) step();
        // randomized traffic
        clear_stage(); s_reset = 1; step();
        s_reset = 0;
        for (int i = 0; i < 2000; i++) begin
            s_reset = ($urandom_range(0, 99) < 2);
            s_rs1d = AW'($urandom_range(0, 7)); s_rs2d = AW'($urandom_range(0, 7));
            s_rs1e = AW'($urandom_range(0, 7)); s_rs2e = AW'($urandom_range(0, 7));
            s_rde = AW'($urandom_range(0, 7)); s_rdm = AW'($urandom_range(0, 7));
            s_rdw = AW'($urandom_range(0, 7));
            s_rwm = 1'($urandom); s_rww = 1'($urandom);
            s_ld = ($urandom_range(0, 3) == 0);
            s_br = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) < 15) s_mul = ~s_mul;
            step();
        end
        clear_stage();
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: %0d responses left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
